// File: rtl/pipelined_muldiv_alu_if.sv
// Request/response bundle for pipelined_muldiv_alu.
//   master : drives Start, Operand1, Operand2, Cntrl, Shamt; observes results.
//   slave  : the ALU side; drives Busy, Done, ALU_OUT, HI_OUT, LO_OUT and flags.
interface pipelined_muldiv_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               Start;
    logic [WIDTH-1:0]   Operand1;
    logic [WIDTH-1:0]   Operand2;
    logic [4:0]         Cntrl;
    logic [SHAMT_W-1:0] Shamt;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   ALU_OUT;
    logic [WIDTH-1:0]   HI_OUT;
    logic [WIDTH-1:0]   LO_OUT;
    logic               NF_OUT, ZF_OUT, OF_OUT, BF_OUT, DZ_OUT;

    modport master (
        output Start, Operand1, Operand2, Cntrl, Shamt,
        input  Busy, Done, ALU_OUT, HI_OUT, LO_OUT,
        input  NF_OUT, ZF_OUT, OF_OUT, BF_OUT, DZ_OUT
    );

    modport slave (
        input  Start, Operand1, Operand2, Cntrl, Shamt,
        output Busy, Done, ALU_OUT, HI_OUT, LO_OUT,
        output NF_OUT, ZF_OUT, OF_OUT, BF_OUT, DZ_OUT
    );
endinterface

// File: rtl/pipelined_muldiv_alu.sv
// EX-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative
// signed/unsigned multiply and divide writing a HI/LO pair.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : slave side of pipelined_muldiv_alu_if (Start/Busy/Done handshake,
//          operands, opcode, shift amount, results and flags)
// Mul/div run as IDLE -> ITER (WIDTH steps) -> FIX (sign correction).
module pipelined_muldiv_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipelined_muldiv_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_nxt;

    logic [4:0]       op;
    logic [WIDTH-1:0] op1, op2;
    logic             is_md, is_div, is_sgn, is_sc, dz;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // acc_hi/acc_lo: product {hi,lo} for multiply, {remainder,quotient} for divide
    logic [WIDTH-1:0] acc_hi, acc_lo, dsor;
    logic [CNT_W-1:0] cnt;
    logic             op_div, neg_lo, neg_hi;

    logic [WIDTH-1:0] alu_out, hi_out, lo_out;
    logic             done, nf, zf, ovf, bf, dzf;

    assign op  = bus.Cntrl;
    assign op1 = bus.Operand1;
    assign op2 = bus.Operand2;

    always_comb begin
        is_md  = (op[4:2] == 3'b100);
        is_div = op[1];
        is_sgn = ~op[0];
        is_sc  = (op <= 5'h0D);
        dz     = is_md && is_div && (op2 == '0);
        a_neg  = is_sgn && op1[WIDTH-1];
        b_neg  = is_sgn && op2[WIDTH-1];
        a_mag  = a_neg ? -op1 : op1;
        b_mag  = b_neg ? -op2 : op2;
    end

    // single-cycle datapath
    logic [WIDTH-1:0]   sc_res, add_r, sub_r;
    logic               sc_of;
    logic [SHAMT_W-1:0] sh;

    always_comb begin
        add_r  = op1 + op2;
        sub_r  = op1 - op2;
        // odd shift codes take the variable amount from rs
        sh     = op[0] ? op1[SHAMT_W-1:0] : bus.Shamt;
        sc_res = '0;
        sc_of  = 1'b0;
        case (op)
            5'h00: sc_res = op1 & op2;
            5'h01: sc_res = op1 | op2;
            5'h02: begin
                sc_res = add_r;
                sc_of  = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_r[WIDTH-1] != op1[WIDTH-1]);
            end
            5'h03: sc_res = op1 ^ op2;
            5'h04: sc_res = ~(op1 | op2);
            5'h05: sc_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            5'h06: begin
                sc_res = sub_r;
                sc_of  = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_r[WIDTH-1] != op1[WIDTH-1]);
            end
            5'h07: sc_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            5'h08, 5'h09: sc_res = op2 << sh;
            5'h0A, 5'h0B: sc_res = op2 >> sh;
            5'h0C, 5'h0D: sc_res = $signed(op2) >>> sh;
            default: sc_res = '0;
        endcase
    end

    // one iteration step and the final sign fix-up
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dsor} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        // invariant rem < divisor keeps the difference's sign bit exact
        div_diff = div_sh - {1'b0, dsor};
        if (op_div) begin
            step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod_neg = -{acc_hi, acc_lo};
        if (op_div) begin
            fix_hi = neg_hi ? -acc_hi : acc_hi;
            fix_lo = neg_lo ? -acc_lo : acc_lo;
        end else begin
            fix_hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
            fix_lo = neg_lo ? prod_neg[WIDTH-1:0]       : acc_lo;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start && is_md && !dz) state_nxt = ITER;
            ITER:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_out <= '0; hi_out <= '0; lo_out <= '0;
            acc_hi  <= '0; acc_lo <= '0; dsor   <= '0; cnt <= '0;
            op_div  <= 1'b0; neg_lo <= 1'b0; neg_hi <= 1'b0;
            done    <= 1'b0; nf <= 1'b0; zf <= 1'b0; ovf <= 1'b0;
            bf      <= 1'b0; dzf <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.Start) begin
                    bf  <= 1'b0;
                    dzf <= 1'b0;
                    if (is_md && dz) begin
                        hi_out <= op1;
                        lo_out <= '1;
                        dzf    <= 1'b1;
                        nf     <= 1'b1;
                        zf     <= 1'b0;
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                    end else if (is_md) begin
                        dsor   <= is_div ? b_mag : a_mag;
                        acc_lo <= is_div ? a_mag : b_mag;
                        acc_hi <= '0;
                        cnt    <= '0;
                        op_div <= is_div;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                    end else if (is_sc) begin
                        alu_out <= sc_res;
                        nf      <= sc_res[WIDTH-1];
                        zf      <= (sc_res == '0);
                        ovf     <= sc_of;
                        done    <= 1'b1;
                    end else begin
                        alu_out <= '0;
                        bf      <= 1'b1;
                        nf      <= 1'b0;
                        zf      <= 1'b1;
                        ovf     <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ITER: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi_out <= fix_hi;
                    lo_out <= fix_lo;
                    nf     <= fix_lo[WIDTH-1];
                    zf     <= (fix_lo == '0);
                    ovf    <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done;
    assign bus.ALU_OUT = alu_out;
    assign bus.HI_OUT  = hi_out;
    assign bus.LO_OUT  = lo_out;
    assign bus.NF_OUT  = nf;
    assign bus.ZF_OUT  = zf;
    assign bus.OF_OUT  = ovf;
    assign bus.BF_OUT  = bf;
    assign bus.DZ_OUT  = dzf;
endmodule

// File: doc/pipelined_muldiv_alu.md
# pipelined_muldiv_alu

Parametrised, clocked successor to the single-cycle MIPS ALU, for the multi-cycle datapath's EX stage. All logical, arithmetic, shift and set-less-than operations return in one cycle. It adds iterative signed/unsigned multiply and divide that write a HI/LO register pair over WIDTH+1 cycles, under a Start/Busy/Done handshake. Results and flags are registered and hold until the next accepted operation.

## Interface
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Operand1  in  WIDTH  rs operand; low SHAMT_W bits are the variable shift amount.
- Operand2  in  WIDTH  rt operand; the value shifted by shift ops.
- Cntrl  in  5  operation code; see Operation.
- Shamt  in  SHAMT_W  immediate shift amount.
- Busy  out  1  multiply/divide in progress.
- Done  out  1  one-cycle pulse when results are valid.
- ALU_OUT  out  WIDTH  single-cycle result.
- HI_OUT, LO_OUT  out  WIDTH each  multiply: high and low product. Divide: HI=remainder, LO=quotient.
- NF_OUT, ZF_OUT, OF_OUT, BF_OUT, DZ_OUT  out  1 each  flags: negative, zero, signed overflow, bad opcode, divide-by-zero.

## Operation
- Single-cycle codes:
  - 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 XOR, 0x04 NOR.
  - 0x05 SLTU, 0x06 SUB, 0x07 SLT (signed).
  - 0x08 SLL by Shamt, 0x09 SLLV by Operand1[SHAMT_W-1:0].
  - 0x0A SRL, 0x0B SRLV, 0x0C SRA, 0x0D SRAV. SRA/SRAV are arithmetic and replicate Operand2[WIDTH-1].
- Iterative codes: 0x10 MULT, 0x11 MULTU, 0x12 DIV, 0x13 DIVU.
- Any other code: BF_OUT=1, ALU_OUT=0, HI/LO unchanged, Done still pulses.
- Single-cycle flags:
  - NF=ALU_OUT[WIDTH-1]; ZF=(ALU_OUT==0).
  - OF = signed overflow, ADD/SUB only; 0 for every other op.
  - HI/LO unchanged.
- Multiply/divide flags: NF/ZF reflect LO_OUT, OF=0, ALU_OUT unchanged.
- FSM states: IDLE, ITER, FIX.
  - IDLE: accepted single-cycle or invalid op stays in IDLE. Accepted mul/div latches operand magnitudes and signs, clears the iteration counter, and goes to ITER.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- Signed rules:
  - Product = two's-complement negation of the 2·WIDTH magnitude product when the operand signs differ.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV of most-negative by −1 gives LO=most-negative, HI=0, OF=0.
- Divide by zero (0x12/0x13 with Operand2=0): detected in IDLE, no ITER. Result: DZ_OUT=1, HI=Operand1, LO=all ones, completes with single-cycle latency. DZ_OUT clears on the next accepted op.

## Timing
- Reset: all outputs 0 (Busy, Done, ALU_OUT, HI, LO, all flags); state IDLE; counter 0.
- Start is accepted at edge E0 when Busy=0. Start while Busy=1 is ignored and has no effect.
- Single-cycle, invalid and divide-by-zero ops: results, flags and Done=1 are valid after E0. Done drops after E1 unless a new op is accepted at E1. Back-to-back issue every cycle is legal.
- Mul/div:
  - Busy=1 from E0 to E_WIDTH+1.
  - Iteration edges are E1..E_WIDTH; the FIX edge E_WIDTH+1 writes HI/LO, sets Done=1 and Busy=0.
  - Latency is WIDTH+1 cycles (33 at WIDTH=32).
  - A new Start may be accepted at E_WIDTH+2.
- Operands and Cntrl need to be valid only at E0; they are internally latched.
- RST during ITER/FIX aborts the operation. After that edge all outputs are 0 and no Done is produced.
- RST and Start asserted in the same cycle: RST wins.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> ALU_OUT=0x80000000, OF=1, NF=1, ZF=0, Done one cycle later. SUB 5−5 -> ALU_OUT=0, ZF=1, OF=0.
- Shifts with Operand2=0x80000000:
  - SRA, Shamt=4 -> 0xF8000000.
  - SRL, Shamt=4 -> 0x08000000.
  - SLLV with Operand1=0x23 (shift 3) and Operand2=0x55555555 -> 0xAAAAAAA8.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, NF=1. Done exactly 33 cycles after the Start edge; Busy high throughout. A second Start mid-operation is ignored.
- Divides:
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- DIVU 9/0 -> DZ=1, HI=9, LO=0xFFFFFFFF, single-cycle Done, Busy never set. Cntrl=0x1F -> BF=1, ALU_OUT=0.
- RST asserted on the 10th cycle of MULTU -> next cycle all outputs 0, Busy=0, no Done. A fresh MULTU 0xFFFFFFFF × 2 then gives HI=1, LO=0xFFFFFFFE.
